// File: rtl/marker_corner_tracker.sv
// rtl/marker_corner_tracker.sv - per-frame marker corner and bounding-box area tracker
module marker_corner_tracker #(
    parameter int p_min_pixels = 64,
    parameter int p_coord_w    = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [p_coord_w-1:0] VGA_X,
    input  logic [p_coord_w-1:0] VGA_Y,
    input  logic                 pixel_valid,
    input  logic                 is_marker,
    input  logic                 frame_end,
    output logic [p_coord_w-1:0] top_left_x,
    output logic [p_coord_w-1:0] top_left_y,
    output logic [p_coord_w-1:0] top_right_x,
    output logic [p_coord_w-1:0] top_right_y,
    output logic [p_coord_w-1:0] bot_left_x,
    output logic [p_coord_w-1:0] bot_left_y,
    output logic [p_coord_w-1:0] bot_right_x,
    output logic [p_coord_w-1:0] bot_right_y,
    output logic [18:0]          scale_amt,
    output logic                 marker_found,
    output logic                 update_valid
);

    localparam int cw = p_coord_w;
    localparam int sw = p_coord_w + 1;

    localparam logic [cw-1:0] coord_max  = {cw{1'b1}};
    localparam logic [sw-1:0] s_max      = {sw{1'b1}};
    localparam logic [sw-1:0] d_max      = {1'b0, {cw{1'b1}}};
    localparam logic [sw-1:0] d_min      = {1'b1, {cw{1'b0}}};
    localparam logic [19:0]   count_max  = 20'hFFFFF;
    localparam logic [19:0]   min_pix    = 20'(p_min_pixels);
    localparam logic [23:0]   area_limit = 24'd524287;

    typedef enum logic {
        st_wait_sync,
        st_accum
    } state_t;

    state_t state_q, state_d;
    logic   hit;
    logic   commit;

    // accumulators for the frame in progress
    logic [sw-1:0] min_s_q, max_s_q, min_d_q, max_d_q;
    logic [cw-1:0] min_s_x_q, min_s_y_q, max_s_x_q, max_s_y_q;
    logic [cw-1:0] min_d_x_q, min_d_y_q, max_d_x_q, max_d_y_q;
    logic [cw-1:0] bb_min_x_q, bb_max_x_q, bb_min_y_q, bb_max_y_q;
    logic [19:0]   pix_count_q;

    logic [sw-1:0] min_s_d, max_s_d, min_d_d, max_d_d;
    logic [cw-1:0] min_s_x_d, min_s_y_d, max_s_x_d, max_s_y_d;
    logic [cw-1:0] min_d_x_d, min_d_y_d, max_d_x_d, max_d_y_d;
    logic [cw-1:0] bb_min_x_d, bb_max_x_d, bb_min_y_d, bb_max_y_d;
    logic [19:0]   pix_count_d;

    logic [sw-1:0] cur_s, cur_d;
    logic          empty;

    // commit stage 1: snapshot of the ended frame
    logic          c1_valid;
    logic [cw-1:0] c1_tl_x, c1_tl_y, c1_tr_x, c1_tr_y;
    logic [cw-1:0] c1_bl_x, c1_bl_y, c1_br_x, c1_br_y;
    logic [cw-1:0] c1_min_x, c1_max_x, c1_min_y, c1_max_y;
    logic [19:0]   c1_count;

    // commit stage 2: box dimensions and pass decision
    logic          c2_valid;
    logic          c2_pass;
    logic [sw-1:0] c2_w, c2_h;
    logic [cw-1:0] c2_tl_x, c2_tl_y, c2_tr_x, c2_tr_y;
    logic [cw-1:0] c2_bl_x, c2_bl_y, c2_br_x, c2_br_y;
    logic [23:0]   c2_area;
    logic [18:0]   c2_scale;

    // frame sync state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= st_wait_sync;
        end else begin
            state_q <= state_d;
        end
    end

    // the first frame_end after reset only aligns to the frame boundary
    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        commit  = 1'b0;
        case (state_q)
            st_wait_sync: begin
                if (frame_end) begin
                    state_d = st_accum;
                end
            end
            st_accum: begin
                hit    = pixel_valid && is_marker;
                commit = frame_end;
            end
            default: begin
                state_d = st_wait_sync;
            end
        endcase
    end

    // next accumulator values including the current pixel; an empty frame loads
    // the first pixel unconditionally so sentinel ties can never leave stale coords
    always_comb begin
        cur_s       = {1'b0, VGA_X} + {1'b0, VGA_Y};
        cur_d       = {1'b0, VGA_X} - {1'b0, VGA_Y};
        empty       = (pix_count_q == 20'd0);
        min_s_d     = min_s_q;
        min_s_x_d   = min_s_x_q;
        min_s_y_d   = min_s_y_q;
        max_s_d     = max_s_q;
        max_s_x_d   = max_s_x_q;
        max_s_y_d   = max_s_y_q;
        min_d_d     = min_d_q;
        min_d_x_d   = min_d_x_q;
        min_d_y_d   = min_d_y_q;
        max_d_d     = max_d_q;
        max_d_x_d   = max_d_x_q;
        max_d_y_d   = max_d_y_q;
        bb_min_x_d  = bb_min_x_q;
        bb_max_x_d  = bb_max_x_q;
        bb_min_y_d  = bb_min_y_q;
        bb_max_y_d  = bb_max_y_q;
        pix_count_d = pix_count_q;
        if (hit) begin
            if (empty || (cur_s < min_s_q)) begin
                min_s_d   = cur_s;
                min_s_x_d = VGA_X;
                min_s_y_d = VGA_Y;
            end
            if (empty || (cur_s > max_s_q)) begin
                max_s_d   = cur_s;
                max_s_x_d = VGA_X;
                max_s_y_d = VGA_Y;
            end
            if (empty || ($signed(cur_d) < $signed(min_d_q))) begin
                min_d_d   = cur_d;
                min_d_x_d = VGA_X;
                min_d_y_d = VGA_Y;
            end
            if (empty || ($signed(cur_d) > $signed(max_d_q))) begin
                max_d_d   = cur_d;
                max_d_x_d = VGA_X;
                max_d_y_d = VGA_Y;
            end
            if (empty || (VGA_X < bb_min_x_q)) bb_min_x_d = VGA_X;
            if (empty || (VGA_X > bb_max_x_q)) bb_max_x_d = VGA_X;
            if (empty || (VGA_Y < bb_min_y_q)) bb_min_y_d = VGA_Y;
            if (empty || (VGA_Y > bb_max_y_q)) bb_max_y_d = VGA_Y;
            if (pix_count_q != count_max) begin
                pix_count_d = pix_count_q + 20'd1;
            end
        end
    end

    // accumulators clear on reset and on every committed frame boundary
    always_ff @(posedge clk) begin
        if (!reset || commit) begin
            min_s_q     <= s_max;
            min_s_x_q   <= '0;
            min_s_y_q   <= '0;
            max_s_q     <= '0;
            max_s_x_q   <= '0;
            max_s_y_q   <= '0;
            min_d_q     <= d_max;
            min_d_x_q   <= '0;
            min_d_y_q   <= '0;
            max_d_q     <= d_min;
            max_d_x_q   <= '0;
            max_d_y_q   <= '0;
            bb_min_x_q  <= coord_max;
            bb_max_x_q  <= '0;
            bb_min_y_q  <= coord_max;
            bb_max_y_q  <= '0;
            pix_count_q <= '0;
        end else if (hit) begin
            min_s_q     <= min_s_d;
            min_s_x_q   <= min_s_x_d;
            min_s_y_q   <= min_s_y_d;
            max_s_q     <= max_s_d;
            max_s_x_q   <= max_s_x_d;
            max_s_y_q   <= max_s_y_d;
            min_d_q     <= min_d_d;
            min_d_x_q   <= min_d_x_d;
            min_d_y_q   <= min_d_y_d;
            max_d_q     <= max_d_d;
            max_d_x_q   <= max_d_x_d;
            max_d_y_q   <= max_d_y_d;
            bb_min_x_q  <= bb_min_x_d;
            bb_max_x_q  <= bb_max_x_d;
            bb_min_y_q  <= bb_min_y_d;
            bb_max_y_q  <= bb_max_y_d;
            pix_count_q <= pix_count_d;
        end
    end

    // stage 1 captures the ending frame, including a pixel coincident with frame_end
    always_ff @(posedge clk) begin
        if (!reset) begin
            c1_valid <= 1'b0;
            c1_tl_x  <= '0;
            c1_tl_y  <= '0;
            c1_tr_x  <= '0;
            c1_tr_y  <= '0;
            c1_bl_x  <= '0;
            c1_bl_y  <= '0;
            c1_br_x  <= '0;
            c1_br_y  <= '0;
            c1_min_x <= '0;
            c1_max_x <= '0;
            c1_min_y <= '0;
            c1_max_y <= '0;
            c1_count <= '0;
        end else begin
            c1_valid <= commit;
            if (commit) begin
                c1_tl_x  <= min_s_x_d;
                c1_tl_y  <= min_s_y_d;
                c1_tr_x  <= max_d_x_d;
                c1_tr_y  <= max_d_y_d;
                c1_bl_x  <= min_d_x_d;
                c1_bl_y  <= min_d_y_d;
                c1_br_x  <= max_s_x_d;
                c1_br_y  <= max_s_y_d;
                c1_min_x <= bb_min_x_d;
                c1_max_x <= bb_max_x_d;
                c1_min_y <= bb_min_y_d;
                c1_max_y <= bb_max_y_d;
                c1_count <= pix_count_d;
            end
        end
    end

    // stage 2 registers box width/height and the pass decision
    always_ff @(posedge clk) begin
        if (!reset) begin
            c2_valid <= 1'b0;
            c2_pass  <= 1'b0;
            c2_w     <= '0;
            c2_h     <= '0;
            c2_tl_x  <= '0;
            c2_tl_y  <= '0;
            c2_tr_x  <= '0;
            c2_tr_y  <= '0;
            c2_bl_x  <= '0;
            c2_bl_y  <= '0;
            c2_br_x  <= '0;
            c2_br_y  <= '0;
        end else begin
            c2_valid <= c1_valid;
            if (c1_valid) begin
                c2_pass <= (c1_count >= min_pix);
                c2_w    <= {1'b0, c1_max_x} - {1'b0, c1_min_x} + {{cw{1'b0}}, 1'b1};
                c2_h    <= {1'b0, c1_max_y} - {1'b0, c1_min_y} + {{cw{1'b0}}, 1'b1};
                c2_tl_x <= c1_tl_x;
                c2_tl_y <= c1_tl_y;
                c2_tr_x <= c1_tr_x;
                c2_tr_y <= c1_tr_y;
                c2_bl_x <= c1_bl_x;
                c2_bl_y <= c1_bl_y;
                c2_br_x <= c1_br_x;
                c2_br_y <= c1_br_y;
            end
        end
    end

    // area of the committed box, clamped to the 19-bit scale range
    always_comb begin
        c2_area  = {{(24-sw){1'b0}}, c2_w} * {{(24-sw){1'b0}}, c2_h};
        c2_scale = (c2_area > area_limit) ? 19'h7FFFF : c2_area[18:0];
    end

    // held outputs: a failing frame only clears marker_found
    always_ff @(posedge clk) begin
        if (!reset) begin
            top_left_x   <= '0;
            top_left_y   <= '0;
            top_right_x  <= '0;
            top_right_y  <= '0;
            bot_left_x   <= '0;
            bot_left_y   <= '0;
            bot_right_x  <= '0;
            bot_right_y  <= '0;
            scale_amt    <= '0;
            marker_found <= 1'b0;
            update_valid <= 1'b0;
        end else begin
            update_valid <= c2_valid;
            if (c2_valid) begin
                marker_found <= c2_pass;
                if (c2_pass) begin
                    top_left_x  <= c2_tl_x;
                    top_left_y  <= c2_tl_y;
                    top_right_x <= c2_tr_x;
                    top_right_y <= c2_tr_y;
                    bot_left_x  <= c2_bl_x;
                    bot_left_y  <= c2_bl_y;
                    bot_right_x <= c2_br_x;
                    bot_right_y <= c2_br_y;
                    scale_amt   <= c2_scale;
                end
            end
        end
    end

endmodule
